apb_master_mp: RTL and testbench
================================

Name: apb_master_mp

Overview:
Parametrised APB3 master for a multi-slave peripheral bus. It accepts single read/write commands on a valid/ready command port and decodes the target slave from the upper address bits. It runs the SETUP/ACCESS protocol with wait states and an optional timeout, then returns data and status on a held response port. It sits between the CPU-side bus bridge and the peripheral slaves, replacing the fixed two-select, 8-bit master.

Parameters:
ADDR_W, 9, PADDR / cmd_addr width.
DATA_W, 8, PWDATA / PRDATA width.
NUM_SLAVES, 2, PSEL lines (>=1).
TIMEOUT, 16, max ACCESS wait cycles before abort; 0 disables.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  master can accept a command.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  ADDR_W  target address.
cmd_wdata  in  DATA_W  write data.
rsp_valid  out  1  response available, held until accepted.
rsp_ready  in  1  response consumed.
rsp_rdata  out  DATA_W  read data (0 for writes and errors).
rsp_err  out  1  PSLVERR, decode error or timeout.
rsp_timeout  out  1  error cause was timeout.
PSEL  out  NUM_SLAVES  one-hot slave select.
PENABLE  out  1  access phase.
PWRITE  out  1  direction.
PADDR  out  ADDR_W  address.
PWDATA  out  DATA_W  write data.
PRDATA  in  NUM_SLAVES*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
PREADY  in  NUM_SLAVES  per-slave ready.
PSLVERR  in  NUM_SLAVES  per-slave error.

Behaviour:
- Clocking and reset: one clock CLK; reset RST_N is asynchronous and active-low. Reset forces state IDLE and clears all outputs (PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_*). Reset mid-transfer aborts the transfer with no response. cmd_ready is 1 once reset is released.
- Decode: SLV_W = max(1, $clog2(NUM_SLAVES)); idx = cmd_addr[ADDR_W-1 -: SLV_W]. If NUM_SLAVES==1, idx is forced to 0. idx >= NUM_SLAVES is a decode error.
- States: IDLE, SETUP, ACCESS, RESP.
  - IDLE: cmd_ready=1. On cmd_valid, latch addr, wdata and write into PADDR/PWDATA/PWRITE. Valid idx -> SETUP; decode error -> RESP with rsp_err=1, rsp_timeout=0 and no PSEL activity.
  - SETUP: PSEL[idx]=1, PENABLE=0. Unconditionally -> ACCESS.
  - ACCESS: PSEL[idx]=1, PENABLE=1; PADDR, PWDATA and PWRITE stable.
    - PREADY[idx]=1: capture PRDATA slice (reads only) and PSLVERR[idx], then -> RESP.
    - Else, if TIMEOUT!=0 and wait counter==TIMEOUT-1: -> RESP with rsp_err=1, rsp_timeout=1, rdata=0.
    - Else increment the counter and stay.
  - RESP: PSEL=0, PENABLE=0, rsp_valid=1. On rsp_ready -> IDLE.
- cmd_ready is 0 in every state except IDLE; a command offered there is held off, not dropped.
- Latency: command accepted at edge T with a zero-wait slave gives SETUP in cycle T+1, ACCESS in T+2, rsp_valid in T+3. Each wait state adds 1 cycle. Minimum command-to-command spacing is 4 cycles.
- Wait counter: $clog2(TIMEOUT+1) bits; cleared on SETUP entry.
- PRDATA, PREADY and PSLVERR of unselected slaves are ignored. Never more than one PSEL bit is high.
- PWDATA holds its last value after a read; PADDR holds after a transfer. Only PSEL and PENABLE return to 0.

Decomposition:
- Package apb_mp_pkg: state enum (IDLE, SETUP, ACCESS, RESP) and SLV_W/counter-width helper functions.
- Sub-module apb_mp_decode: combinational addr -> one-hot select plus decode-error flag; instantiated once.

Test Plan:
- Write addr 0x105, data 0xA5, slave 1 PREADY=1 -> PSEL=2'b10 in T+1 (PENABLE 0), PENABLE=1 in T+2, rsp_valid T+3, rsp_err=0, rdata=0.
- Read addr 0x010, slave 0 PREADY low 3 cycles, PRDATA=0x3C -> ACCESS held 4 cycles, PADDR stable, rsp_rdata=0x3C.
- Read with PSLVERR[0]=1 at PREADY -> rsp_err=1, rsp_timeout=0.
- TIMEOUT=16, slave never ready -> exactly 16 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_timeout=1.
- NUM_SLAVES=3, ADDR_W=9, addr 0x1C0 (idx 3) -> no PSEL, rsp_valid next cycle, rsp_err=1.
- RST_N low during ACCESS -> PSEL/PENABLE 0 asynchronously, no rsp_valid; cmd_ready=1 after release. rsp_ready held low 5 cycles -> rsp_valid/rdata stable and cmd_ready=0 throughout.

Source files
------------

// File: rtl/apb_mp_pkg.sv
// apb_mp_pkg
//   Shared definitions for the multi-slave APB3 master:
//   - FSM state encoding (IDLE, SETUP, ACCESS, RESP)
//   - slv_w(): width of the slave-index field taken from the top of the address
//   - cnt_w(): width of the ACCESS wait-state counter for a given timeout
package apb_mp_pkg;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t ST_IDLE   = 2'd0;
  localparam apb_state_t ST_SETUP  = 2'd1;
  localparam apb_state_t ST_ACCESS = 2'd2;
  localparam apb_state_t ST_RESP   = 2'd3;

  // At least one index bit, even for a single slave, so the decode port
  // never collapses to zero width.
  function automatic int slv_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter must hold 0..TIMEOUT-1; a disabled timeout still gets one bit.
  function automatic int cnt_w(input int t);
    return (t <= 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/apb_mp_decode.sv
// apb_mp_decode
//   Combinational slave decode for the APB master.
//   Ports:
//     addr_hi  in   SLV_W       upper address bits holding the slave index
//     sel      out  NUM_SLAVES  one-hot select (all zero on decode error)
//     dec_err  out  1           index points past the last slave
module apb_mp_decode #(
  parameter int NUM_SLAVES = 2,
  parameter int SLV_W      = 1
) (
  input  logic [SLV_W-1:0]      addr_hi,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  dec_err
);

  generate
    if (NUM_SLAVES == 1) begin : g_single
      // Only one target: the index bits carry no information.
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_hi;
      assign sel            = 1'b1;
      assign dec_err        = 1'b0;
    end else begin : g_multi
      // Extra leading bit so NUM_SLAVES itself fits when it is a power of two.
      assign dec_err = ({1'b0, addr_hi} >= (SLV_W+1)'(NUM_SLAVES));
      for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
        assign sel[i] = ~dec_err && (addr_hi == SLV_W'(i));
      end
    end
  endgenerate

endmodule

// File: rtl/apb_master_mp.sv
// apb_master_mp
//   Parametrised APB3 master for a multi-slave peripheral bus. Takes single
//   read/write commands on a valid/ready port, decodes the slave from the top
//   address bits, runs SETUP/ACCESS with wait states and an optional timeout,
//   and returns data/status on a response port held until accepted.
//   Ports:
//     CLK, RST_N                clock (rising), async active-low reset
//     cmd_valid/ready           command handshake
//     cmd_write/addr/wdata      command payload
//     rsp_valid/ready           response handshake (held until rsp_ready)
//     rsp_rdata                 read data, 0 for writes and any error
//     rsp_err, rsp_timeout      error flag, and whether it came from timeout
//     PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB request side
//     PRDATA/PREADY/PSLVERR     per-slave APB response side (slave i at slice i)
module apb_master_mp
  import apb_mp_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         rsp_timeout,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int SLV_W = slv_w(NUM_SLAVES);
  localparam int CNT_W = cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_t              state;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic [CNT_W-1:0]        cnt;

  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_err;

  logic [DATA_W-1:0]       rdata_mux;
  logic                    ready_mux;
  logic                    err_mux;
  logic                    to_hit;

  // Decode straight off the command port so the IDLE cycle can choose
  // between SETUP and an immediate error response.
  apb_mp_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_W      (SLV_W)
  ) u_decode (
    .addr_hi (cmd_addr[ADDR_W-1 -: SLV_W]),
    .sel     (dec_sel),
    .dec_err (dec_err)
  );

  // One-hot AND-OR select: anything an unselected slave drives is masked.
  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) rdata_mux |= PRDATA[i*DATA_W +: DATA_W];
    end
  end

  assign ready_mux = |(PREADY & sel_q);
  assign err_mux   = |(PSLVERR & sel_q);

  // Last permitted wait cycle; constant-false when the timeout is disabled.
  assign to_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      sel_q       <= '0;
      cnt         <= '0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            PADDR       <= cmd_addr;
            PWDATA      <= cmd_wdata;
            PWRITE      <= cmd_write;
            sel_q       <= dec_sel;
            cnt         <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= dec_err;
            rsp_timeout <= 1'b0;
            // A bad index never touches the bus: straight to the response.
            state       <= dec_err ? ST_RESP : ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt   <= '0;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A ready on the final permitted cycle still wins over the timeout.
          if (ready_mux) begin
            rsp_rdata   <= (!PWRITE && !err_mux) ? rdata_mux : '0;
            rsp_err     <= err_mux;
            rsp_timeout <= 1'b0;
            state       <= ST_RESP;
          end else if (to_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus strobes come from the state alone, so an async reset drops them
  // immediately and at most one PSEL bit (sel_q is one-hot) is ever high.
  assign PSEL      = (state == ST_SETUP || state == ST_ACCESS) ? sel_q : '0;
  assign PENABLE   = (state == ST_ACCESS);
  assign rsp_valid = (state == ST_RESP);
  assign cmd_ready = (state == ST_IDLE);

endmodule

// File: tb/tb_apb_master_mp.sv
// tb_apb_master_mp
//   Two instances: "a" uses the default 2-slave/8-bit/TIMEOUT=16 build with
//   a randomised slave responder; "b" is a 3-slave build used for decode
//   coverage including an out-of-range index.
module tb_apb_master_mp;

  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance a: 2 slaves ----------------
  logic        a_cmd_valid, a_cmd_ready, a_cmd_write;
  logic [8:0]  a_cmd_addr;
  logic [7:0]  a_cmd_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err, a_rsp_timeout;
  logic [7:0]  a_rsp_rdata;
  logic [1:0]  a_psel;
  logic        a_penable, a_pwrite;
  logic [8:0]  a_paddr;
  logic [7:0]  a_pwdata;
  logic [15:0] a_prdata;
  logic [1:0]  a_pready, a_pslverr;

  apb_master_mp #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(2), .TIMEOUT(TMO)) dut_a (
    .CLK(clk), .RST_N(rst_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
    .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .rsp_timeout(a_rsp_timeout),
    .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite), .PADDR(a_paddr),
    .PWDATA(a_pwdata), .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr)
  );

  // Slave behaviour: the selected slave raises PREADY after sl_wait ACCESS
  // cycles; unselected slaves drive random junk every cycle.
  int          sl_wait = 0;
  bit          sl_err = 1'b0;
  logic [7:0]  sl_rdata = 8'h00;
  int          acc_cnt = 0;
  logic [15:0] nz_rdata = 16'h0;
  logic [1:0]  nz_rdy = 2'b0, nz_err = 2'b0;

  always @(negedge clk) begin
    nz_rdata <= 16'($urandom);
    nz_rdy   <= 2'($urandom);
    nz_err   <= 2'($urandom);
  end

  always @(posedge clk) acc_cnt <= a_penable ? acc_cnt + 1 : 0;

  always_comb begin
    a_prdata  = nz_rdata;
    a_pready  = nz_rdy;
    a_pslverr = nz_err;
    for (int i = 0; i < 2; i++) begin
      if (a_psel[i]) begin
        a_pready[i]        = a_penable && (acc_cnt == sl_wait);
        a_pslverr[i]       = sl_err;
        a_prdata[i*8 +: 8] = sl_rdata;
      end
    end
  end

  // One transaction on instance a, checked against the transfer-level rules:
  // 1 SETUP cycle, min(wait+1, TMO) ACCESS cycles, then a held response.
  task automatic do_a(input bit wr, input logic [8:0] addr, input logic [7:0] wd,
                      input int w, input bit e, input logic [7:0] rd, input int hold);
    bit         to_exp, err_exp;
    int         n_exp, cyc, setup_n, acc_n, sel_bad, bus_bad, rdy_bad, hold_bad, guard, k;
    logic [1:0] sel_exp;
    logic [7:0] rd_exp, h_rd;
    logic       h_err, h_to;
    to_exp  = (w >= TMO);
    n_exp   = to_exp ? TMO : w + 1;
    err_exp = to_exp | e;
    rd_exp  = (wr || err_exp) ? 8'h00 : rd;
    sel_exp = 2'b01 << addr[8];

    sl_wait = w; sl_err = e; sl_rdata = rd;
    a_cmd_valid = 1'b1; a_cmd_write = wr; a_cmd_addr = addr; a_cmd_wdata = wd;
    guard = 0;
    while (!a_cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    chk("a_accept", 32'(guard < 20), 1);
    @(negedge clk);
    a_cmd_valid = 1'b0;
    a_cmd_addr  = 9'($urandom);
    a_cmd_wdata = 8'($urandom);
    a_cmd_write = 1'($urandom);

    cyc = 0; setup_n = 0; acc_n = 0; sel_bad = 0; bus_bad = 0; rdy_bad = 0;
    while (!a_rsp_valid && cyc < 40) begin
      if (cyc == 0) chk("a_setup_first", {30'd0, |a_psel, a_penable}, 2'b10);
      if (|a_psel) begin
        if (a_penable) acc_n++; else setup_n++;
        if (a_psel != sel_exp) sel_bad++;
        if (a_paddr != addr || a_pwrite != wr || (wr && a_pwdata != wd)) bus_bad++;
      end else begin
        bus_bad++;
      end
      if (a_cmd_ready) rdy_bad++;
      cyc++;
      @(negedge clk);
    end
    chk("a_rsp_latency", cyc, n_exp + 1);
    chk("a_setup_cycles", setup_n, 1);
    chk("a_access_cycles", acc_n, n_exp);
    chk("a_psel_onehot", sel_bad, 0);
    chk("a_bus_stable", bus_bad, 0);
    chk("a_cmd_ready_busy", rdy_bad, 0);
    chk("a_rsp_bus_idle", {29'd0, a_psel, a_penable}, 0);
    chk("a_rsp_err", a_rsp_err, err_exp);
    chk("a_rsp_timeout", a_rsp_timeout, to_exp);
    chk("a_rsp_rdata", a_rsp_rdata, rd_exp);

    k = (hold < 0) ? $urandom_range(0, 5) : hold;
    a_rsp_ready = 1'b0;
    h_rd = a_rsp_rdata; h_err = a_rsp_err; h_to = a_rsp_timeout;
    hold_bad = 0;
    repeat (k) begin
      @(negedge clk);
      if (!a_rsp_valid || a_rsp_rdata != h_rd || a_rsp_err != h_err ||
          a_rsp_timeout != h_to || a_cmd_ready || |a_psel) hold_bad++;
    end
    chk("a_rsp_hold", hold_bad, 0);
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    chk("a_rsp_release", {30'd0, a_rsp_valid, a_cmd_ready}, 2'b01);
  endtask

  // ---------------- instance b: 3 slaves ----------------
  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [8:0]  b_cmd_addr;
  logic [7:0]  b_cmd_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_rsp_timeout;
  logic [7:0]  b_rsp_rdata;
  logic [2:0]  b_psel;
  logic        b_penable, b_pwrite;
  logic [8:0]  b_paddr;
  logic [7:0]  b_pwdata;
  logic [23:0] b_prdata;
  logic [2:0]  b_pready, b_pslverr;

  apb_master_mp #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(3), .TIMEOUT(TMO)) dut_b (
    .CLK(clk), .RST_N(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .rsp_timeout(b_rsp_timeout),
    .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite), .PADDR(b_paddr),
    .PWDATA(b_pwdata), .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
  );

  // Slaves of b are always ready; slave i returns 0x11*(i+1).
  task automatic do_b(input logic [8:0] addr, input bit wr);
    int         idx, cyc, lat_exp, guard;
    bit         derr;
    logic [2:0] sel_exp, sel_seen;
    logic [7:0] rd_exp;
    idx     = int'(addr[8:7]);
    derr    = (idx >= 3);
    sel_exp = derr ? 3'b000 : 3'(1 << idx);
    rd_exp  = (wr || derr) ? 8'h00 : 8'(8'h11 * (idx + 1));
    lat_exp = derr ? 0 : 2;

    b_cmd_valid = 1'b1; b_cmd_write = wr; b_cmd_addr = addr; b_cmd_wdata = 8'($urandom);
    guard = 0;
    while (!b_cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    chk("b_accept", 32'(guard < 20), 1);
    @(negedge clk);
    b_cmd_valid = 1'b0;
    cyc = 0; sel_seen = 3'b000;
    while (!b_rsp_valid && cyc < 10) begin
      sel_seen |= b_psel;
      cyc++;
      @(negedge clk);
    end
    chk("b_rsp_latency", cyc, lat_exp);
    chk("b_psel_seen", sel_seen, sel_exp);
    chk("b_rsp_err", b_rsp_err, derr);
    chk("b_rsp_timeout", b_rsp_timeout, 0);
    chk("b_rsp_rdata", b_rsp_rdata, rd_exp);
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
    chk("b_rsp_release", b_rsp_valid, 0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int r, w, bad, guard;
    rst_n = 1'b0;
    a_cmd_valid = 1'b0; a_cmd_write = 1'b0; a_cmd_addr = '0; a_cmd_wdata = '0; a_rsp_ready = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_write = 1'b0; b_cmd_addr = '0; b_cmd_wdata = '0; b_rsp_ready = 1'b0;
    b_pready = 3'b111; b_pslverr = 3'b000; b_prdata = 24'h332211;

    repeat (2) @(negedge clk);
    chk("rst_bus", {a_psel, a_penable, a_pwrite, a_paddr, a_pwdata}, 0);
    chk("rst_rsp", {a_rsp_valid, a_rsp_err, a_rsp_timeout, a_rsp_rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", a_cmd_ready, 1);

    // Directed cases
    do_a(1'b1, 9'h105, 8'hA5, 0, 1'b0, 8'h5A, 0);      // zero-wait write to slave 1
    do_a(1'b0, 9'h010, 8'h00, 3, 1'b0, 8'h3C, 5);      // 3 waits, rsp held 5 cycles
    do_a(1'b0, 9'h020, 8'h00, 1, 1'b1, 8'h77, 0);      // PSLVERR
    do_a(1'b0, 9'h100, 8'h00, 1000, 1'b0, 8'h99, 1);   // never ready -> timeout
    do_a(1'b0, 9'h1FF, 8'h00, 15, 1'b0, 8'hC3, 0);     // ready on last allowed cycle
    do_a(1'b1, 9'h0F0, 8'h12, 16, 1'b0, 8'h00, 0);     // one cycle too late

    // Randomised traffic
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      case (r)
        6:       w = 15;
        7:       w = 16;
        8:       w = 1000;
        9:       w = $urandom_range(6, 14);
        default: w = r;
      endcase
      do_a(1'($urandom), 9'($urandom), 8'($urandom), w,
           ($urandom_range(0, 4) == 0), 8'($urandom), -1);
    end

    // Instance b decode coverage
    do_b(9'h1C0, 1'b0);
    do_b(9'h1C0, 1'b1);
    do_b(9'h000, 1'b0);
    do_b(9'h080, 1'b0);
    do_b(9'h100, 1'b0);
    do_b(9'h145, 1'b1);
    for (int t = 0; t < 12; t++) do_b(9'($urandom), 1'($urandom));

    // Reset in the middle of ACCESS
    sl_wait = 1000; sl_err = 1'b0;
    a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_addr = 9'h0AA;
    guard = 0;
    while (!a_cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    a_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_in_access", {30'd0, |a_psel, a_penable}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_async_bus", {29'd0, a_psel, a_penable}, 0);
    chk("rst_mid_no_rsp", a_rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_rsp_valid || !a_cmd_ready || |a_psel || a_penable) bad++;
    end
    chk("rst_mid_after_release", bad, 0);

    do_a(1'b0, 9'h033, 8'h00, 2, 1'b0, 8'h6B, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
